// File: rtl/ins_fetch.sv
// ins_fetch -- instruction fetch unit feeding the decode stage.
//
// Fetches 32-bit instructions one byte at a time from a byte-wide memory
// port, assembles them little-endian and queues them with their PC in a
// FIFO. Decode pops the FIFO head. A redirect flushes the FIFO and restarts
// fetching at the redirect target.
//
// Ports:
//   clk_in    - clock, rising edge active
//   rst_in    - synchronous active-low reset
//   mem_req   - byte read request to the memory arbiter
//   mem_gnt   - arbiter grant, only looked at while idle
//   mem_a     - byte address presented this cycle
//   mem_din   - read data for the address accepted in the previous cycle
//   jump_en   - redirect strobe
//   jump_pc   - redirect target PC
//   ins_valid - FIFO head is valid
//   ins       - head instruction word
//   ins_pc    - PC of the head instruction
//   ins_take  - pop the FIFO head this cycle
module ins_fetch #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_a,
  input  logic [7:0]  mem_din,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_take
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [1:0]    k_q, k_d;
  logic [23:0]   stage_q, stage_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   fifo_pc_q  [DEPTH];
  logic [31:0]   fifo_ins_q [DEPTH];

  logic          push;
  logic          pop;
  logic          req_int;
  logic [31:0]   addr_int;

  // Fetch sequencer, FIFO bookkeeping and redirect handling.
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    k_d      = k_q;
    stage_d  = stage_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push     = 1'b0;
    req_int  = 1'b0;
    addr_int = fpc_q;

    unique case (state_q)
      IDLE: begin
        // A fetch starts only with room in the FIFO, so the later push
        // can never overflow even if nothing is popped meanwhile.
        req_int = (count_q < CW'(DEPTH)) && !jump_en;
        if (req_int && mem_gnt) begin
          state_d = FETCH;
          k_d     = 2'd1;
        end
      end
      FETCH: begin
        req_int  = 1'b1;
        addr_int = fpc_q + {30'd0, k_q};
        // mem_din carries the byte requested one cycle earlier (k-1).
        unique case (k_q)
          2'd1:    stage_d[7:0]   = mem_din;
          2'd2:    stage_d[15:8]  = mem_din;
          2'd3:    stage_d[23:16] = mem_din;
          default: stage_d        = stage_q;
        endcase
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = DRAIN;
          k_d     = 2'd0;
        end
      end
      DRAIN: begin
        push    = 1'b1;
        fpc_d   = fpc_q + 32'd4;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pop = ins_take && (count_q != '0);

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Redirect wins over any push or pop in the same cycle.
    if (jump_en) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fpc_d    = jump_pc;
      state_d  = IDLE;
      k_d      = 2'd0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      fpc_q    <= RESET_PC;
      k_q      <= 2'd0;
      stage_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      k_q      <= k_d;
      stage_q  <= stage_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible through count.
  // A write during a redirect lands in a slot that is then logically empty.
  always_ff @(posedge clk_in) begin
    if (rst_in && push) begin
      fifo_pc_q[wr_ptr_q]  <= fpc_q;
      fifo_ins_q[wr_ptr_q] <= {mem_din, stage_q};
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    mem_req   = rst_in && req_int;
    mem_a     = rst_in ? addr_int : 32'd0;
    ins_valid = rst_in && (count_q != '0);
    ins       = rst_in ? fifo_ins_q[rd_ptr_q] : 32'd0;
    ins_pc    = rst_in ? fifo_pc_q[rd_ptr_q] : 32'd0;
  end

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch unit: the producer side of the decode interface. It fetches 32-bit instructions from the byte-wide memory port, assembles them little-endian, and buffers them with their PC in a FIFO. The decode/issue stage pops the FIFO one instruction at a time. A redirect from the branch/jump logic flushes the FIFO and restarts fetch at a new PC.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries; power of two, ≥2.
- `RESET_PC`, default 32'h0: fetch PC after reset.

Ports:
- `clk_in` input 1: the single clock; all state changes on its rising edge.
- `rst_in` input 1: reset; synchronous, active-low.
- `mem_req` output 1: byte-read request to the memory arbiter.
- `mem_gnt` input 1: arbiter grant; sampled only in IDLE.
- `mem_a` output 32: byte address presented this cycle.
- `mem_din` input 8: read data for the address accepted in the previous cycle.
- `jump_en` input 1: redirect strobe.
- `jump_pc` input 32: redirect target.
- `ins_valid` output 1: FIFO head valid.
- `ins` output 32: head instruction word, to `Decode.ins`.
- `ins_pc` output 32: PC of the head instruction.
- `ins_take` input 1: pop the head this cycle.

## Operation
- State: `fpc` (32 b), FSM {IDLE, FETCH, DRAIN}, byte index `k` (2 b), 24-bit byte staging register, FIFO of {pc, ins}, `count` (0..DEPTH).
- IDLE:
  - `mem_req` = 1 iff `count` < DEPTH and not `jump_en`; `mem_a` = `fpc`.
  - On `mem_req && mem_gnt`: byte 0 is accepted; go to FETCH with `k`=1.
  - Otherwise hold, with `mem_a` stable.
- FETCH:
  - `mem_req` = 1, `mem_a` = `fpc`+k.
  - `mem_din` carries byte k-1; store it into the staging register.
  - Increment `k`; after k=3 go to DRAIN.
- DRAIN:
  - `mem_req` = 0, `mem_a` = `fpc`.
  - `mem_din` = byte 3. Push {`fpc`, {byte3, byte2, byte1, byte0}} into the FIFO.
  - `fpc` ← `fpc`+4; go to IDLE.
- Only one fetch is in flight at a time. A fetch starts only when `count` < DEPTH, so the push in DRAIN never overflows.
- Address arithmetic is mod 2^32: `fpc`+k and `fpc`+4 wrap silently.
- Byte order is little-endian: byte at `fpc` → `ins[7:0]`, byte at `fpc`+3 → `ins[31:24]`.
- FIFO outputs:
  - `ins_valid` = (`count` != 0); `ins`/`ins_pc` = head entry, combinational from the FIFO registers.
  - `ins_take` with `ins_valid` = 1 pops; `ins_take` with `ins_valid` = 0 is ignored.
  - Push and pop in the same cycle: `count` is unchanged and both take effect, including when `count` = DEPTH−1.
  - Read and write pointers wrap mod DEPTH.
- Redirect (`jump_en` = 1 at a clock edge):
  - FIFO cleared (`count` ← 0, pointers ← 0); `fpc` ← `jump_pc`; FSM ← IDLE; `k` ← 0.
  - Any in-flight bytes are discarded, including the `mem_din` byte in the following cycle, which IDLE ignores.
  - Redirect has priority over a same-cycle push (DRAIN) and pop (`ins_take`).
  - While `jump_en` = 1 in IDLE, `mem_req` = 0.
- Reset (`rst_in` = 0 at an edge):
  - `fpc` ← `RESET_PC`, FSM ← IDLE, `count`/pointers/`k` ← 0.
  - Reset overrides redirect and any transfer in progress.
  - While `rst_in` = 0, `mem_req` = 0, `mem_a` = 0, `ins_valid` = 0, `ins` = 0, `ins_pc` = 0.

## Timing
- Grant in cycle t. Addresses `fpc`..`fpc`+3 are presented in t..t+3; bytes arrive on `mem_din` in t+1..t+4. The push happens at the end of t+4, and `ins_valid` = 1 in t+5 if the FIFO was empty.
- Back-to-back fetches: the next `mem_req` rises in t+5 (IDLE). Sustained throughput is one instruction per 5 cycles with `mem_gnt` = 1 continuously.
- A pop at the edge ending cycle c shows the next entry, or `ins_valid` = 0, in c+1.
- After redirect at the edge ending cycle c: `mem_req` = 1 with `mem_a` = `jump_pc` in c+1 (if `jump_en` = 0 then). The earliest new instruction is valid in c+6.
- `mem_a` changes only on state/`k`/`fpc` updates; no mid-cycle dependency on `mem_gnt` except the IDLE→FETCH decision.

## Test plan
- Reset: hold `rst_in` = 0 for 3 cycles, then release → `mem_req` = 1, `mem_a` = 0x0 in the first cycle after release; `ins_valid` = 0.
- Single fetch: memory bytes 0x93,0x00,0x50,0x00 at 0x0..0x3, `mem_gnt` = 1 → in t+5, `ins_valid` = 1, `ins` = 0x00500093, `ins_pc` = 0x0; next `mem_a` = 0x4.
- Fill/full: never assert `ins_take` → after 16 pushes `mem_req` stays 0. Pop once → one more fetch starts at `fpc` = 0x40. Push+pop in the same cycle at `count` = 15 → `count` stays 15.
- Grant stall: `mem_gnt` = 0 for 3 cycles in IDLE → `mem_req` = 1, `mem_a` constant, no FIFO change; fetch proceeds normally once granted.
- Redirect mid-burst: `jump_en` with `jump_pc` = 0x100 in FETCH (k=2) while the FIFO holds 2 entries → next cycle `ins_valid` = 0, `mem_a` = 0x100. The first pushed entry has `ins_pc` = 0x100; no entry for the aborted PC appears.
- Wraparound: redirect to 0xFFFFFFFC → addresses 0xFFFFFFFC..0xFFFFFFFF are fetched, the entry has `ins_pc` = 0xFFFFFFFC, and the next `mem_a` = 0x00000000.
